// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcodes, control-field layout and main-control decode
//                for the MIPS ID stage.
//  Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam int CTLWB_W      = 2;
    localparam int CTLM_W       = 3;
    localparam int CTLEX_W      = 4;
    localparam int CTLM_MEMREAD = 1;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite},
    // ex = {RegDst, ALUOp[1:0], ALUSrc}
    typedef struct packed {
        logic [CTLWB_W-1:0] wb;
        logic [CTLM_W-1:0]  m;
        logic [CTLEX_W-1:0] ex;
    } ctl_t;

    function automatic ctl_t decode_op(input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.wb = 2'b10;
                c.ex = {1'b1, ALUOP_RTYPE, 1'b0};
            end
            OP_LW: begin
                c.wb = 2'b11;
                c.m  = 3'b010;
                c.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_SW: begin
                c.m  = 3'b001;
                c.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_BEQ: begin
                c.m  = 3'b100;
                c.ex = {1'b0, ALUOP_SUB, 1'b0};
            end
            OP_ADDI: begin
                c.wb = 2'b10;
                c.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idecode_hz_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : Two-read / one-write register file, $0 hardwired to zero,
//                with write-through bypass from the write port.
//  Revision    : 1.0
// ============================================================================
module regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [REG_AW-1:0] rt_idx,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wen,
    input  logic [REG_AW-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    localparam logic [REG_AW:0] c_nreg = (REG_AW+1)'(NREG);

    logic [DATA_W-1:0] r_mem [NREG];
    logic [REG_AW-1:0] w_ridx [2];
    logic [DATA_W-1:0] w_rdat [2];
    logic              w_we;

    assign w_we      = wen && (wr_idx != '0) && ({1'b0, wr_idx} < c_nreg);
    assign w_ridx[0] = rs_idx;
    assign w_ridx[1] = rt_idx;
    assign rs_data   = w_rdat[0];
    assign rt_data   = w_rdat[1];

    // Out-of-range indices read zero even if the write port names them.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdat[p] = '0;
            if ((w_ridx[p] != '0) && ({1'b0, w_ridx[p]} < c_nreg)) begin
                if (w_we && (wr_idx == w_ridx[p]))
                    w_rdat[p] = wr_data;
                else
                    w_rdat[p] = r_mem[w_ridx[p]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/idecode_hz.sv
`default_nettype none
// ============================================================================
//  Module      : idecode_hz
//  Description : MIPS ID stage - register read, main decode, load-use hazard
//                stall, branch flush and the ID/EX pipeline register.
//  Revision    : 1.0
// ============================================================================
module idecode_hz
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ID_ir,
    input  logic [DATA_W-1:0]  ID_npc,
    input  logic               WB_wen,
    input  logic [DATA_W-1:0]  WB_wdata,
    input  logic [REG_AW-1:0]  WB_rd,
    input  logic               ID_flush,
    output logic               ID_stall,
    output logic [CTLWB_W-1:0] EX_ctlwb,
    output logic [CTLM_W-1:0]  EX_ctlm,
    output logic [CTLEX_W-1:0] EX_ctlex,
    output logic [DATA_W-1:0]  EX_npc,
    output logic [DATA_W-1:0]  EX_rd1,
    output logic [DATA_W-1:0]  EX_rd2,
    output logic [DATA_W-1:0]  EX_imm,
    output logic [REG_AW-1:0]  EX_rs,
    output logic [REG_AW-1:0]  EX_rt,
    output logic [REG_AW-1:0]  EX_rd
);

    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_imm;
    ctl_t              w_ctl;
    logic              w_raw_hz;
    logic              w_bubble;

    assign w_rs  = REG_AW'(ID_ir[25:21]);
    assign w_rt  = REG_AW'(ID_ir[20:16]);
    assign w_rd  = REG_AW'(ID_ir[15:11]);
    assign w_imm = {{(DATA_W-16){ID_ir[15]}}, ID_ir[15:0]};
    assign w_ctl = decode_op(ID_ir[31:26]);

    regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_idx  (w_rs),
        .rt_idx  (w_rt),
        .rs_data (w_rd1),
        .rt_data (w_rd2),
        .wen     (WB_wen),
        .wr_idx  (WB_rd),
        .wr_data (WB_wdata)
    );

    // Load in EX whose destination is read here: its data is not ready yet.
    assign w_raw_hz = EX_ctlm[CTLM_MEMREAD] && (EX_rt != '0) &&
                      ((EX_rt == w_rs) || (EX_rt == w_rt));
    assign ID_stall = w_raw_hz && !ID_flush;
    assign w_bubble = ID_flush || w_raw_hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EX_ctlwb <= '0;
            EX_ctlm  <= '0;
            EX_ctlex <= '0;
            EX_npc   <= '0;
            EX_rd1   <= '0;
            EX_rd2   <= '0;
            EX_imm   <= '0;
            EX_rs    <= '0;
            EX_rt    <= '0;
            EX_rd    <= '0;
        end else begin
            if (w_bubble) begin
                EX_ctlwb <= '0;
                EX_ctlm  <= '0;
                EX_ctlex <= '0;
            end else begin
                EX_ctlwb <= w_ctl.wb;
                EX_ctlm  <= w_ctl.m;
                EX_ctlex <= w_ctl.ex;
            end
            EX_npc <= ID_npc;
            EX_rd1 <= w_rd1;
            EX_rd2 <= w_rd2;
            EX_imm <= w_imm;
            EX_rs  <= w_rs;
            EX_rt  <= w_rt;
            EX_rd  <= w_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idecode_hz.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idecode_hz
//  Description : Directed self-checking bench for idecode_hz (32- and 64-bit).
//  Revision    : 1.0
// ============================================================================
module tb_idecode_hz;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ID_ir;
    logic [31:0] ID_npc;
    logic        WB_wen;
    logic [31:0] WB_wdata;
    logic [4:0]  WB_rd;
    logic        ID_flush;

    logic        ID_stall;
    logic [1:0]  EX_ctlwb;
    logic [2:0]  EX_ctlm;
    logic [3:0]  EX_ctlex;
    logic [31:0] EX_npc, EX_rd1, EX_rd2, EX_imm;
    logic [4:0]  EX_rs, EX_rt, EX_rd;

    logic [63:0] npc64, wdata64;
    logic        stall64;
    logic [1:0]  ctlwb64;
    logic [2:0]  ctlm64;
    logic [3:0]  ctlex64;
    logic [63:0] enpc64, rd1_64, rd2_64, imm64;
    logic [4:0]  rs64, rt64, rd64;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign npc64   = {32'h0, ID_npc};
    assign wdata64 = {32'h0, WB_wdata};

    idecode_hz u_dut (
        .clk(clk), .rst(rst), .ID_ir(ID_ir), .ID_npc(ID_npc),
        .WB_wen(WB_wen), .WB_wdata(WB_wdata), .WB_rd(WB_rd),
        .ID_flush(ID_flush), .ID_stall(ID_stall),
        .EX_ctlwb(EX_ctlwb), .EX_ctlm(EX_ctlm), .EX_ctlex(EX_ctlex),
        .EX_npc(EX_npc), .EX_rd1(EX_rd1), .EX_rd2(EX_rd2), .EX_imm(EX_imm),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd)
    );

    idecode_hz #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .ID_ir(ID_ir), .ID_npc(npc64),
        .WB_wen(WB_wen), .WB_wdata(wdata64), .WB_rd(WB_rd),
        .ID_flush(ID_flush), .ID_stall(stall64),
        .EX_ctlwb(ctlwb64), .EX_ctlm(ctlm64), .EX_ctlex(ctlex64),
        .EX_npc(enpc64), .EX_rd1(rd1_64), .EX_rd2(rd2_64), .EX_imm(imm64),
        .EX_rs(rs64), .EX_rt(rt64), .EX_rd(rd64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] wb,
                             input logic [2:0] m, input logic [3:0] ex);
        check({tag, "_wb"}, {62'h0, EX_ctlwb}, {62'h0, wb});
        check({tag, "_m"},  {61'h0, EX_ctlm},  {61'h0, m});
        check({tag, "_ex"}, {60'h0, EX_ctlex}, {60'h0, ex});
    endtask

    task automatic wb_write(input logic [4:0] idx, input logic [31:0] val);
        WB_wen = 1'b1; WB_rd = idx; WB_wdata = val;
        step();
        WB_wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ID_ir = 32'hFC00_0000; ID_npc = '0;
        WB_wen = 1'b0; WB_wdata = '0; WB_rd = '0; ID_flush = 1'b0;
        step(); step();
        rst = 1'b0;
        check_ctl("rst", 2'b00, 3'b000, 4'b0000);
        check("rst_rd1", {32'h0, EX_rd1}, 64'h0);
        check("rst_stall", {63'h0, ID_stall}, 64'h0);

        // unknown opcode, no hazard
        step();
        check_ctl("unk", 2'b00, 3'b000, 4'b0000);

        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);

        // add $3,$1,$2
        ID_ir = 32'h0022_1820; ID_npc = 32'h104;
        step();
        check_ctl("add", 2'b10, 3'b000, 4'b1100);
        check("add_rs", {59'h0, EX_rs}, 64'd1);
        check("add_rt", {59'h0, EX_rt}, 64'd2);
        check("add_rd", {59'h0, EX_rd}, 64'd3);
        check("add_rd1", {32'h0, EX_rd1}, 64'h11);
        check("add_rd2", {32'h0, EX_rd2}, 64'h22);
        check("add_npc", {32'h0, EX_npc}, 64'h104);

        // asynchronous reset mid-run clears outputs and register file
        rst = 1'b1;
        #1;
        check_ctl("arst", 2'b00, 3'b000, 4'b0000);
        check("arst_rs", {59'h0, EX_rs}, 64'd0);
        check("arst_rd1", {32'h0, EX_rd1}, 64'h0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_rd1", {32'h0, EX_rd1}, 64'h0);
        check_ctl("post_rst", 2'b10, 3'b000, 4'b1100);

        // write-through bypass: add $7,$5,$0 while writing $5
        ID_ir = 32'h00A0_3820;
        wb_write(5'd5, 32'hDEAD_BEEF);
        check("byp_rd1", {32'h0, EX_rd1}, 64'hDEAD_BEEF);
        step();
        check("wr_rd1", {32'h0, EX_rd1}, 64'hDEAD_BEEF);

        // writes to $0 are ignored, also by the bypass
        ID_ir = 32'h0000_3820;
        wb_write(5'd0, 32'h1234_5678);
        check("r0_byp", {32'h0, EX_rd1}, 64'h0);
        step();
        check("r0_rd", {32'h0, EX_rd1}, 64'h0);

        ID_ir = 32'hFC00_0000;
        wb_write(5'd1, 32'h100);
        wb_write(5'd2, 32'h22);

        // load-use: lw $4,8($1) then add $6,$4,$2
        ID_ir = 32'h8C24_0008;
        #1;
        check("lw_stall_pre", {63'h0, ID_stall}, 64'h0);
        step();
        check_ctl("lw", 2'b11, 3'b010, 4'b0001);
        check("lw_rt", {59'h0, EX_rt}, 64'd4);
        check("lw_imm", {32'h0, EX_imm}, 64'h8);
        check("lw_rd1", {32'h0, EX_rd1}, 64'h100);
        ID_ir = 32'h0082_3020;
        #1;
        check("lu_stall", {63'h0, ID_stall}, 64'h1);
        step();
        check_ctl("lu_bubble", 2'b00, 3'b000, 4'b0000);
        check("lu_stall_end", {63'h0, ID_stall}, 64'h0);
        step();
        check_ctl("lu_add", 2'b10, 3'b000, 4'b1100);
        check("lu_add_rs", {59'h0, EX_rs}, 64'd4);
        check("lu_add_rd", {59'h0, EX_rd}, 64'd6);

        // negative immediate, both widths
        ID_ir = 32'h8C24_FFFC;
        step();
        check("imm32", {32'h0, EX_imm}, 64'h0000_0000_FFFF_FFFC);
        check("imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("ctlm64", {61'h0, ctlm64}, 64'h2);

        // flush beats stall
        ID_ir = 32'h0082_3020; ID_flush = 1'b1;
        #1;
        check("fl_stall", {63'h0, ID_stall}, 64'h0);
        step();
        check_ctl("fl_bubble", 2'b00, 3'b000, 4'b0000);

        // flush alone on sw
        ID_ir = 32'hAC24_0000;
        step();
        check_ctl("fl_sw", 2'b00, 3'b000, 4'b0000);
        ID_flush = 1'b0;
        step();
        check_ctl("sw", 2'b00, 3'b001, 4'b0001);

        ID_ir = 32'h1022_0010;
        step();
        check_ctl("beq", 2'b00, 3'b100, 4'b0010);
        ID_ir = 32'h2025_FFFF;
        step();
        check_ctl("addi", 2'b10, 3'b000, 4'b0001);
        check("addi_imm", {32'h0, EX_imm}, 64'hFFFF_FFFF);

        // unknown opcode reading a pending load destination still stalls
        ID_ir = 32'h8C24_0008;
        step();
        ID_ir = 32'hFC80_0000;
        #1;
        check("unk_stall", {63'h0, ID_stall}, 64'h1);
        step();
        check_ctl("unk_bubble", 2'b00, 3'b000, 4'b0000);
        check("unk_stall_end", {63'h0, ID_stall}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idecode_hz.md
Name: idecode_hz

Overview:
- Parametrised next-generation MIPS ID stage: register file, main control decode and the ID/EX pipeline register.
- Adds load-use hazard detection, which stalls IF/ID and inserts an ID/EX bubble.
- Adds a flush input for taken branches and write-through bypass from WB.
- Sits between ifetch (IF/ID regs ID_ir, ID_npc) and the EX stage; outputs EX_rs for the forwarding unit.

Parameters:
- DATA_W, 32, datapath width: register contents, npc, immediate.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- REG_AW, 5, register index width; must satisfy 2**REG_AW >= NREG; the instruction fields rs/rt/rd are 5 bits, zero-extended or truncated to REG_AW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_ir  in  32  instruction from IF/ID.
- ID_npc  in  DATA_W  PC+4 from IF/ID.
- WB_wen  in  1  register write enable.
- WB_wdata  in  DATA_W  register write data.
- WB_rd  in  REG_AW  register write index.
- ID_flush  in  1  taken branch resolved in MEM; kill the ID instruction.
- ID_stall  out  1  load-use hazard; ifetch holds PC and IF/ID.
- EX_ctlwb  out  2  {RegWrite, MemtoReg}.
- EX_ctlm  out  3  {Branch, MemRead, MemWrite}.
- EX_ctlex  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- EX_npc  out  DATA_W  registered npc.
- EX_rd1  out  DATA_W  registered rs data.
- EX_rd2  out  DATA_W  registered rt data.
- EX_imm  out  DATA_W  registered sign-extended immediate.
- EX_rs  out  REG_AW  registered rs index.
- EX_rt  out  REG_AW  registered rt index.
- EX_rd  out  REG_AW  registered rd index.

Behaviour:
- Reset (async, any time, including mid-stall): all EX_* outputs go to 0 and all registers clear to 0. ID_stall is combinational, so it reads 0 once EX_ctlm is 0.
- Decode uses opcode ID_ir[31:26]. The resulting {ctlwb, ctlm, ctlex} values are:
  - R-type 0x00: 10, 000, 1100.
  - lw 0x23: 11, 010, 0001.
  - sw 0x2B: 00, 001, 0001.
  - beq 0x04: 00, 100, 0010.
  - addi 0x08: 10, 000, 0001.
  - Any other opcode: all zero (NOP).
- Register read is combinational on rs = ID_ir[25:21] and rt = ID_ir[20:16].
  - Index 0, or an index >= NREG, reads 0.
- Write-through bypass: if WB_wen is set, WB_rd is nonzero and WB_rd equals the read index, the read returns WB_wdata in the same cycle.
- Register writes occur on the rising edge when WB_wen=1 and WB_rd is nonzero and < NREG. Other writes are ignored.
- Immediate: ID_ir[15:0] sign-extended to DATA_W.
- Hazard: raw_hz = EX_ctlm[1] && EX_rt!=0 && (EX_rt==rs || EX_rt==rt).
  - ID_stall = raw_hz && !ID_flush.
- ID/EX register, updated on every rising edge (latency 1 cycle):
  - Bubble case (ID_flush || raw_hz): ctlwb, ctlm and ctlex load 0; data and index fields still load the current values (don't-care).
  - Otherwise all fields load the decoded values.
- Flush has priority over stall. A flush drops ID_stall in the same cycle.
- A stall persists exactly one cycle per load-use pair, because the bubble clears EX_ctlm[1].

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI).
  - Control field widths and bit positions (CTLWB_W=2, CTLM_W=3, CTLEX_W=4, CTLM_MEMREAD=1).
  - ALUOp encodings.
- Sub-module regfile (parametrised DATA_W/NREG/REG_AW): two combinational read ports with write-through bypass, one synchronous write port, async clear on rst.
- Decode, hazard logic and the ID/EX register stay in idecode_hz.

Test Plan:
- Reset/basic decode: assert rst mid-run → all EX_* read 0 immediately. Release, present R-type add $3,$1,$2 → next edge EX_ctlwb=10, EX_ctlm=000, EX_ctlex=1100, EX_rs=1, EX_rt=2, EX_rd=3.
- Writeback and bypass:
  - WB_wen=1, WB_rd=5, WB_wdata=0xDEADBEEF with rs=5 in ID in the same cycle → EX_rd1=0xDEADBEEF after the edge.
  - WB_rd=0 → a later read of $0 returns 0.
- Load-use: lw $4,8($1) followed by add $6,$4,$2 → ID_stall=1 for exactly one cycle and EX controls=0 (bubble). Next cycle the add is latched with ctlwb=10.
- Immediates: lw with imm 0xFFFC → EX_imm=0xFFFFFFFC (DATA_W=32). Repeat with DATA_W=64 → 0xFFFFFFFFFFFFFFFC.
- Flush vs stall: load-use condition plus ID_flush=1 in the same cycle → ID_stall=0 and EX controls=0. With flush alone on a sw → EX_ctlm=000.
- Unknown opcode: 0x3F → all controls 0; ID_stall=0 unless raw_hz is true.
